// File: rtl/axi_lite_pkg.sv
`default_nettype none
// ============================================================================
// Module  : axi_lite_pkg
// Brief   : AXI4-Lite response codes and crossbar FSM state types.
// Revision: 1.0
// ============================================================================
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_DATA = 2'd1,
        WR_RESP = 2'd2
    } wr_state_t;

    typedef enum logic [0:0] {
        RD_IDLE = 1'b0,
        RD_RESP = 1'b1
    } rd_state_t;

endpackage
`default_nettype wire

// File: rtl/axi_lite_addr_decoder.sv
`default_nettype none
// ============================================================================
// Module  : axi_lite_addr_decoder
// Brief   : Base/mask address decode, lowest matching slot wins; no match
//           selects the error target (index NUM_SLAVES).
// Revision: 1.0
// ============================================================================
module axi_lite_addr_decoder #(
    parameter int NUM_SLAVES = 2,
    parameter int ADDR_WIDTH = 32,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_ADDR_BASES = {32'h1000_0000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_ADDR_MASKS = {32'hF000_0000, 32'hF000_0000},
    localparam int SEL_W = $clog2(NUM_SLAVES + 1)
) (
    input  logic [ADDR_WIDTH-1:0] addr_i,
    output logic [SEL_W-1:0]      sel_o
);

    always_comb begin
        sel_o = SEL_W'(NUM_SLAVES);
        // Walk downwards so the lowest matching index is the last to assign.
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((addr_i & SLAVE_ADDR_MASKS[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
                (SLAVE_ADDR_BASES[i*ADDR_WIDTH +: ADDR_WIDTH] & SLAVE_ADDR_MASKS[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
                sel_o = SEL_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/axi_lite_xbar_1ton.sv
`default_nettype none
// ============================================================================
// Module  : axi_lite_xbar_1ton
// Brief   : 1-master to N-slave AXI4-Lite crossbar with DECERR responder.
// Revision: 1.0
// ============================================================================
module axi_lite_xbar_1ton
    import axi_lite_pkg::*;
#(
    parameter int NUM_SLAVES = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_ADDR_BASES = {32'h1000_0000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_ADDR_MASKS = {32'hF000_0000, 32'hF000_0000},
    localparam int STRB_W = DATA_WIDTH / 8,
    localparam int SEL_W  = $clog2(NUM_SLAVES + 1)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             m_axi_awvalid_i,
    output logic                             m_axi_awready_o,
    input  logic [ADDR_WIDTH-1:0]            m_axi_awaddr_i,
    input  logic [2:0]                       m_axi_awprot_i,
    input  logic                             m_axi_wvalid_i,
    output logic                             m_axi_wready_o,
    input  logic [DATA_WIDTH-1:0]            m_axi_wdata_i,
    input  logic [STRB_W-1:0]                m_axi_wstrb_i,
    output logic                             m_axi_bvalid_o,
    input  logic                             m_axi_bready_i,
    output logic [1:0]                       m_axi_bresp_o,
    input  logic                             m_axi_arvalid_i,
    output logic                             m_axi_arready_o,
    input  logic [ADDR_WIDTH-1:0]            m_axi_araddr_i,
    input  logic [2:0]                       m_axi_arprot_i,
    output logic                             m_axi_rvalid_o,
    input  logic                             m_axi_rready_i,
    output logic [DATA_WIDTH-1:0]            m_axi_rdata_o,
    output logic [1:0]                       m_axi_rresp_o,
    output logic [NUM_SLAVES-1:0]            s_axi_awvalid_o,
    input  logic [NUM_SLAVES-1:0]            s_axi_awready_i,
    output logic [NUM_SLAVES*ADDR_WIDTH-1:0] s_axi_awaddr_o,
    output logic [NUM_SLAVES*3-1:0]          s_axi_awprot_o,
    output logic [NUM_SLAVES-1:0]            s_axi_wvalid_o,
    input  logic [NUM_SLAVES-1:0]            s_axi_wready_i,
    output logic [NUM_SLAVES*DATA_WIDTH-1:0] s_axi_wdata_o,
    output logic [NUM_SLAVES*STRB_W-1:0]     s_axi_wstrb_o,
    input  logic [NUM_SLAVES-1:0]            s_axi_bvalid_i,
    output logic [NUM_SLAVES-1:0]            s_axi_bready_o,
    input  logic [NUM_SLAVES*2-1:0]          s_axi_bresp_i,
    output logic [NUM_SLAVES-1:0]            s_axi_arvalid_o,
    input  logic [NUM_SLAVES-1:0]            s_axi_arready_i,
    output logic [NUM_SLAVES*ADDR_WIDTH-1:0] s_axi_araddr_o,
    output logic [NUM_SLAVES*3-1:0]          s_axi_arprot_o,
    input  logic [NUM_SLAVES-1:0]            s_axi_rvalid_i,
    output logic [NUM_SLAVES-1:0]            s_axi_rready_o,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_axi_rdata_i,
    input  logic [NUM_SLAVES*2-1:0]          s_axi_rresp_i
);

    localparam logic [SEL_W-1:0] C_ERR_SEL = SEL_W'(NUM_SLAVES);

    wr_state_t        wr_state_q;
    rd_state_t        rd_state_q;
    logic [SEL_W-1:0] wsel_q;
    logic [SEL_W-1:0] rsel_q;
    logic [SEL_W-1:0] w_dec_aw;
    logic [SEL_W-1:0] w_dec_ar;

    axi_lite_addr_decoder #(
        .NUM_SLAVES       (NUM_SLAVES),
        .ADDR_WIDTH       (ADDR_WIDTH),
        .SLAVE_ADDR_BASES (SLAVE_ADDR_BASES),
        .SLAVE_ADDR_MASKS (SLAVE_ADDR_MASKS)
    ) u_dec_aw (
        .addr_i (m_axi_awaddr_i),
        .sel_o  (w_dec_aw)
    );

    axi_lite_addr_decoder #(
        .NUM_SLAVES       (NUM_SLAVES),
        .ADDR_WIDTH       (ADDR_WIDTH),
        .SLAVE_ADDR_BASES (SLAVE_ADDR_BASES),
        .SLAVE_ADDR_MASKS (SLAVE_ADDR_MASKS)
    ) u_dec_ar (
        .addr_i (m_axi_araddr_i),
        .sel_o  (w_dec_ar)
    );

    assign s_axi_awaddr_o = {NUM_SLAVES{m_axi_awaddr_i}};
    assign s_axi_awprot_o = {NUM_SLAVES{m_axi_awprot_i}};
    assign s_axi_wdata_o  = {NUM_SLAVES{m_axi_wdata_i}};
    assign s_axi_wstrb_o  = {NUM_SLAVES{m_axi_wstrb_i}};
    assign s_axi_araddr_o = {NUM_SLAVES{m_axi_araddr_i}};
    assign s_axi_arprot_o = {NUM_SLAVES{m_axi_arprot_i}};

    always_comb begin
        s_axi_awvalid_o = '0;
        s_axi_wvalid_o  = '0;
        s_axi_bready_o  = '0;
        m_axi_awready_o = 1'b0;
        m_axi_wready_o  = 1'b0;
        m_axi_bvalid_o  = 1'b0;
        m_axi_bresp_o   = RESP_OKAY;
        case (wr_state_q)
            WR_IDLE: begin
                if (w_dec_aw == C_ERR_SEL) begin
                    m_axi_awready_o = 1'b1;
                end
                for (int i = 0; i < NUM_SLAVES; i++) begin
                    if (w_dec_aw == SEL_W'(i)) begin
                        s_axi_awvalid_o[i] = m_axi_awvalid_i;
                        m_axi_awready_o    = s_axi_awready_i[i];
                    end
                end
            end
            WR_DATA: begin
                if (wsel_q == C_ERR_SEL) begin
                    m_axi_wready_o = 1'b1;
                end
                for (int i = 0; i < NUM_SLAVES; i++) begin
                    if (wsel_q == SEL_W'(i)) begin
                        s_axi_wvalid_o[i] = m_axi_wvalid_i;
                        m_axi_wready_o    = s_axi_wready_i[i];
                    end
                end
            end
            WR_RESP: begin
                if (wsel_q == C_ERR_SEL) begin
                    m_axi_bvalid_o = 1'b1;
                    m_axi_bresp_o  = RESP_DECERR;
                end
                for (int i = 0; i < NUM_SLAVES; i++) begin
                    if (wsel_q == SEL_W'(i)) begin
                        m_axi_bvalid_o    = s_axi_bvalid_i[i];
                        m_axi_bresp_o     = s_axi_bresp_i[i*2 +: 2];
                        s_axi_bready_o[i] = m_axi_bready_i;
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        s_axi_arvalid_o = '0;
        s_axi_rready_o  = '0;
        m_axi_arready_o = 1'b0;
        m_axi_rvalid_o  = 1'b0;
        m_axi_rdata_o   = '0;
        m_axi_rresp_o   = RESP_OKAY;
        case (rd_state_q)
            RD_IDLE: begin
                if (w_dec_ar == C_ERR_SEL) begin
                    m_axi_arready_o = 1'b1;
                end
                for (int i = 0; i < NUM_SLAVES; i++) begin
                    if (w_dec_ar == SEL_W'(i)) begin
                        s_axi_arvalid_o[i] = m_axi_arvalid_i;
                        m_axi_arready_o    = s_axi_arready_i[i];
                    end
                end
            end
            RD_RESP: begin
                if (rsel_q == C_ERR_SEL) begin
                    m_axi_rvalid_o = 1'b1;
                    m_axi_rresp_o  = RESP_DECERR;
                end
                for (int i = 0; i < NUM_SLAVES; i++) begin
                    if (rsel_q == SEL_W'(i)) begin
                        m_axi_rvalid_o    = s_axi_rvalid_i[i];
                        m_axi_rdata_o     = s_axi_rdata_i[i*DATA_WIDTH +: DATA_WIDTH];
                        m_axi_rresp_o     = s_axi_rresp_i[i*2 +: 2];
                        s_axi_rready_o[i] = m_axi_rready_i;
                    end
                end
            end
            default: ;
        endcase
    end

    // One FSM step per handshake; the decoded target is frozen at address acceptance.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_state_q <= WR_IDLE;
            rd_state_q <= RD_IDLE;
            wsel_q     <= '0;
            rsel_q     <= '0;
        end else begin
            case (wr_state_q)
                WR_IDLE: if (m_axi_awvalid_i && m_axi_awready_o) begin
                    wsel_q     <= w_dec_aw;
                    wr_state_q <= WR_DATA;
                end
                WR_DATA: if (m_axi_wvalid_i && m_axi_wready_o) wr_state_q <= WR_RESP;
                WR_RESP: if (m_axi_bvalid_o && m_axi_bready_i) wr_state_q <= WR_IDLE;
                default: wr_state_q <= WR_IDLE;
            endcase
            case (rd_state_q)
                RD_IDLE: if (m_axi_arvalid_i && m_axi_arready_o) begin
                    rsel_q     <= w_dec_ar;
                    rd_state_q <= RD_RESP;
                end
                RD_RESP: if (m_axi_rvalid_o && m_axi_rready_i) rd_state_q <= RD_IDLE;
                default: rd_state_q <= RD_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
